// File: rtl/inst_cache.sv
// inst_cache: direct-mapped, read-only instruction cache.
// A fetch that hits returns its instruction in the same cycle. A miss raises
// outStall and a refill FSM loads the whole line from backing memory, one
// word per mem_ready. Also provides a whole-cache invalidate (fence.i) and
// hit/miss statistics counters.
//
// Ports:
//   clock, reset      - clock; asynchronous active-low reset
//   addressInst       - byte fetch address (pc); bits [1:0] are ignored
//   outInst, outStall - fetched instruction (NOP while stalled), stall flag
//   invalidate        - clears every valid bit and abandons any refill
//   mem_req, mem_addr - refill word request and word-aligned address
//   mem_ready         - mem_rdata holds the requested word this cycle
//   mem_rdata         - refill data
//   hit_count         - number of fetch cycles that hit
//   miss_count        - number of line refills started
//
// state | meaning
// ------+--------------------------------------------------------
// IDLE  | serving hits; a miss latches the line and starts a refill
// FILL  | requesting words cnt = 0..WORDS-1 of the latched line
module inst_cache #(
   parameter int          INDEX_BITS  = 4,
   parameter int          OFFSET_BITS = 2,
   parameter logic [31:0] NOP         = 32'h0000_0013
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] addressInst,
   output logic [31:0] outInst,
   output logic        outStall,
   input  logic        invalidate,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
);

   localparam int LINES    = 1 << INDEX_BITS;
   localparam int WORDS    = 1 << OFFSET_BITS;
   localparam int TAG_BITS = 30 - INDEX_BITS - OFFSET_BITS;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] FILL = 1'b1;

   logic [0:0]             state;
   logic [LINES-1:0]       valid;
   logic [TAG_BITS-1:0]    tag_store [LINES];
   // Data is flattened so a word is addressed by {index, offset}.
   logic [31:0]            data [LINES*WORDS];

   logic [TAG_BITS-1:0]    fill_tag;
   logic [INDEX_BITS-1:0]  fill_index;
   logic [OFFSET_BITS-1:0] cnt;

   logic [OFFSET_BITS-1:0] offset;
   logic [INDEX_BITS-1:0]  index;
   logic [TAG_BITS-1:0]    tag;
   logic                   hit;
   logic                   last_word;
   logic                   word_done;
   logic                   unused_addr_bits;

   assign offset = addressInst[OFFSET_BITS+1:2];
   assign index  = addressInst[INDEX_BITS+OFFSET_BITS+1:OFFSET_BITS+2];
   assign tag    = addressInst[31:INDEX_BITS+OFFSET_BITS+2];
   assign unused_addr_bits = ^addressInst[1:0];

   // Hits are only served from IDLE, so the refill in progress never aliases
   // a partially written line as valid.
   assign hit      = (state == IDLE) && valid[index] && (tag_store[index] == tag);
   assign outStall = ~hit;
   assign outInst  = hit ? data[{index, offset}] : NOP;

   assign last_word = (cnt == {OFFSET_BITS{1'b1}});
   assign word_done = (state == FILL) && mem_ready;

   assign mem_req  = (state == FILL);
   assign mem_addr = (state == FILL) ? {fill_tag, fill_index, cnt, 2'b00} : 32'h0;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         valid      <= '0;
         cnt        <= '0;
         fill_tag   <= '0;
         fill_index <= '0;
         hit_count  <= 32'h0;
         miss_count <= 32'h0;
      end else begin
         if (invalidate) begin
            // Abandons any refill; the half-written line simply stays invalid.
            valid <= '0;
            state <= IDLE;
            cnt   <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (!hit) begin
                     fill_tag   <= tag;
                     fill_index <= index;
                     cnt        <= '0;
                     miss_count <= miss_count + 32'd1;
                     state      <= FILL;
                  end
               end
               FILL: begin
                  if (mem_ready) begin
                     cnt <= cnt + 1'b1;
                     if (last_word) begin
                        valid[fill_index] <= 1'b1;
                        state             <= IDLE;
                     end
                  end
               end
            endcase
         end
         if (hit) begin
            hit_count <= hit_count + 32'd1;
         end
      end
   end

   // Storage arrays carry no reset; valid bits alone decide what is usable.
   always_ff @(posedge clock) begin
      if (word_done) begin
         data[{fill_index, cnt}] <= mem_rdata;
         if (last_word) begin
            tag_store[fill_index] <= fill_tag;
         end
      end
   end

endmodule

// File: tb/tb_inst_cache.sv
// tb_inst_cache: self-checking bench for inst_cache.
// Backing memory model: word n (byte address 4n) holds 0x1000 + n.
module tb_inst_cache;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clock;
   logic        reset;
   logic [31:0] addressInst;
   logic [31:0] outInst;
   logic        outStall;
   logic        invalidate;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic [31:0] hit_count;
   logic [31:0] miss_count;

   inst_cache dut (
      .clock       (clock),
      .reset       (reset),
      .addressInst (addressInst),
      .outInst     (outInst),
      .outStall    (outStall),
      .invalidate  (invalidate),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ready   (mem_ready),
      .mem_rdata   (mem_rdata),
      .hit_count   (hit_count),
      .miss_count  (miss_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   assign mem_rdata = 32'h1000 + {2'b00, mem_addr[31:2]};

   int checks = 0;
   int errors = 0;
   int rdy_period = 1;
   int cyc = 0;
   logic [31:0] seen[$];

   typedef struct {
      logic [31:0] addr;
      logic [31:0] inst;
      logic        stall;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      checks++;
      errors++;
      $display("FAIL %s timeout waiting on DUT", nm);
   endtask

   // One clock cycle: log any word consumed this cycle, advance to the next
   // falling edge, drive the ready pattern, settle.
   task automatic step();
      if (mem_req && mem_ready) seen.push_back(mem_addr);
      @(posedge clock);
      @(negedge clock);
      cyc++;
      mem_ready = (rdy_period == 1) || ((cyc % rdy_period) == 0);
      #1;
   endtask

   task automatic fetch(input logic [31:0] a, input logic [31:0] exp_inst,
                        input int exp_stall, input string nm);
      int n;
      n = 0;
      seen.delete();
      addressInst = a;
      #1;
      while (outStall && n < 60) begin
         step();
         n++;
      end
      if (outStall) timeout(nm);
      else begin
         chk({nm, " stall cycles"}, n, exp_stall);
         chk({nm, " inst"}, outInst, exp_inst);
      end
   endtask

   task automatic chk_line(input logic [31:0] base, input int first, input string nm);
      for (int i = 0; i < 4; i++) begin
         if (seen.size() > first + i) chk(nm, seen[first + i], base + 32'(4 * i));
         else timeout(nm);
      end
   endtask

   initial begin
      int n;
      logic [31:0] exp_seq[8];

      tbl[0] = '{32'h0, 32'h1000, 1'b0};
      tbl[1] = '{32'h4, 32'h1001, 1'b0};
      tbl[2] = '{32'h8, 32'h1002, 1'b0};
      tbl[3] = '{32'hC, 32'h1003, 1'b0};
      tbl[4] = '{32'h3, 32'h1000, 1'b0};
      tbl[5] = '{32'hE, 32'h1003, 1'b0};

      reset       = 1'b0;
      addressInst = 32'h0;
      invalidate  = 1'b0;
      mem_ready   = 1'b1;
      #1;
      chk("reset stall", outStall, 1'b1);
      chk("reset inst", outInst, NOP);
      chk("reset mem_req", mem_req, 1'b0);
      chk("reset mem_addr", mem_addr, 32'h0);
      chk("reset hits", hit_count, 32'h0);
      chk("reset misses", miss_count, 32'h0);
      @(negedge clock);
      reset = 1'b1;
      #1;

      // Cold miss with ready tied high.
      fetch(32'h0, 32'h1000, 5, "cold");
      chk_line(32'h0, 0, "cold mem_addr");
      chk("cold misses", miss_count, 32'd1);
      chk("cold hits", hit_count, 32'd0);

      // Same-cycle hits over the filled line.
      for (int i = 0; i < 6; i++) begin
         addressInst = tbl[i].addr;
         #1;
         chk($sformatf("tbl%0d inst", i), outInst, tbl[i].inst);
         chk($sformatf("tbl%0d stall", i), outStall, tbl[i].stall);
         step();
      end
      chk("tbl hits", hit_count, 32'd6);
      chk("tbl misses", miss_count, 32'd1);

      // Conflict on index 0.
      fetch(32'h0,   32'h1000, 0, "conf a");
      fetch(32'h100, 32'h1040, 5, "conf b");
      chk_line(32'h100, 0, "conf b mem_addr");
      fetch(32'h0,   32'h1000, 5, "conf c");
      chk("conf misses", miss_count, 32'd3);

      // Slow memory with the pc moved mid-fill.
      rdy_period = 3;
      cyc = 0;
      mem_ready = 1'b0;
      seen.delete();
      addressInst = 32'h200;
      #1;
      n = 0;
      while (seen.size() < 2 && n < 60) begin step(); n++; end
      addressInst = 32'h40;
      #1;
      while (outStall && n < 120) begin step(); n++; end
      if (outStall) timeout("slow fill");
      for (int i = 0; i < 4; i++) exp_seq[i] = 32'h200 + 32'(4 * i);
      for (int i = 0; i < 4; i++) exp_seq[i+4] = 32'h40 + 32'(4 * i);
      chk("slow words", seen.size(), 32'd8);
      for (int i = 0; i < 8; i++) begin
         if (seen.size() > i) chk($sformatf("slow addr%0d", i), seen[i], exp_seq[i]);
      end
      chk("slow inst", outInst, 32'h1010);
      chk("slow misses", miss_count, 32'd5);
      rdy_period = 1;
      mem_ready = 1'b1;
      fetch(32'h200, 32'h1080, 0, "slow line0");

      // Invalidate mid-fill at cnt=2.
      seen.delete();
      addressInst = 32'h300;
      #1;
      n = 0;
      while (!(mem_req && mem_addr == 32'h308) && n < 20) begin step(); n++; end
      if (n >= 20) timeout("inv reach cnt2");
      invalidate = 1'b1;
      step();
      invalidate = 1'b0;
      chk("inv mem_req", mem_req, 1'b0);
      chk("inv mem_addr", mem_addr, 32'h0);
      chk("inv stall", outStall, 1'b1);
      fetch(32'h0, 32'h1000, 5, "inv refetch");
      chk_line(32'h0, 0, "inv mem_addr");
      chk("inv misses", miss_count, 32'd7);

      // Invalidate together with an IDLE miss starts no fill.
      addressInst = 32'h40;
      invalidate  = 1'b1;
      step();
      invalidate = 1'b0;
      chk("idle inv mem_req", mem_req, 1'b0);
      chk("idle inv misses", miss_count, 32'd7);
      fetch(32'h40, 32'h1010, 5, "idle inv refetch");
      chk("idle inv misses2", miss_count, 32'd8);

      // Asynchronous reset mid-fill.
      seen.delete();
      addressInst = 32'h100;
      #1;
      n = 0;
      while (seen.size() < 2 && n < 20) begin step(); n++; end
      reset = 1'b0;
      #1;
      chk("rst mem_req", mem_req, 1'b0);
      chk("rst mem_addr", mem_addr, 32'h0);
      chk("rst hits", hit_count, 32'h0);
      chk("rst misses", miss_count, 32'h0);
      chk("rst stall", outStall, 1'b1);
      chk("rst inst", outInst, NOP);
      @(negedge clock);
      reset = 1'b1;
      fetch(32'h0, 32'h1000, 5, "post rst");
      chk_line(32'h0, 0, "post rst mem_addr");
      chk("post rst misses", miss_count, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/inst_cache.md
Name: inst_cache

Overview:
- Direct-mapped, read-only instruction cache between the core's fetch port (pc / instruction) and a slower backing instruction memory.
- Hits return the instruction combinationally in the same cycle.
- Misses raise outStall, which the core uses to freeze its pipeline clock, while a refill FSM fetches the whole line word by word over a req/ready handshake.
- Also provides a whole-cache invalidate (fence.i) and hit/miss statistics counters.

Parameters:
- INDEX_BITS, 4, log2 number of lines (16 lines).
- OFFSET_BITS, 2, log2 words per line (4 words, 16 bytes).
- NOP, 32'h00000013, instruction driven on outInst while stalled.

Ports:
- clock, input, 1, single clock; all state updates on rising edge.
- reset, input, 1, asynchronous, active-low.
- addressInst, input, 32, byte fetch address (pc); bits [1:0] ignored.
- outInst, output, 32, fetched instruction.
- outStall, output, 1, 1 = instruction not yet available; core must hold pc.
- invalidate, input, 1, clear all valid bits (fence.i).
- mem_req, output, 1, refill word request.
- mem_addr, output, 32, word-aligned refill address.
- mem_ready, input, 1, backing memory returns mem_rdata this cycle.
- mem_rdata, input, 32, refill data.
- hit_count, output, 32, fetch hits.
- miss_count, output, 32, misses (one per line refill started).

Behaviour:
- Address split: offset = addressInst[OFFSET_BITS+1:2]; index = next INDEX_BITS bits; tag = remaining upper bits.
- Storage: per line, a valid bit, a tag and 2^OFFSET_BITS data words.

Hit logic:
- hit = (state==IDLE) & valid[index] & (tag_store[index]==tag). Purely combinational from addressInst.
- outStall = ~hit.
- outInst = data[index][offset] when hit, else NOP.

FSM states and transitions:
- IDLE:
  - On a miss with invalidate=0: latch tag/index into fill registers, clear word counter cnt, increment miss_count, go to FILL.
  - On a hit: increment hit_count each cycle.
- FILL:
  - mem_req=1; mem_addr={fill_tag, fill_index, cnt, 2'b00}.
  - On mem_ready: write mem_rdata into data[fill_index][cnt] and increment cnt.
  - When mem_ready arrives with cnt == all-ones: write tag_store, set valid[fill_index], go to IDLE.
  - mem_req may remain 1 across consecutive words; each mem_ready consumes exactly one word.
- After a fill, the first cycle back in IDLE re-evaluates addressInst. The fill itself counts neither as a hit nor as a second miss.

Boundary conditions:
- addressInst changes during FILL: ignored. The fill completes for the latched line, then the new address is evaluated (may miss again).
- invalidate in any state: all valid bits cleared next edge; FSM forced to IDLE; cnt cleared; mem_req low from next cycle. The backing memory must tolerate an abandoned request.
- invalidate in IDLE with a miss the same cycle: no fill starts; miss_count not incremented.
- mem_ready while in IDLE: ignored.
- Counters wrap modulo 2^32.
- reset low (async, also mid-fill):
  - all valid bits cleared; state=IDLE; cnt=0; mem_req=0; mem_addr=0; hit_count=miss_count=0.
  - outStall=1 and outInst=NOP, since nothing is valid.
  - Data and tag arrays need not be reset.

Output summary:
- Refill latency is 2^OFFSET_BITS ready cycles.
- Minimum miss penalty is 1 + 4 cycles with mem_ready tied high.

Test Plan:
- Reset, then addressInst=0x0, mem_ready tied high, memory word n = 0x1000+n -> outStall=1 for 5 cycles; mem_addr sequence 0x0, 0x4, 0x8, 0xC; then outInst=0x1000, outStall=0; miss_count=1.
- After the previous fill, sweep addressInst 0x0, 0x4, 0x8, 0xC -> each is a same-cycle hit returning 0x1000..0x1003; hit_count increments by 4.
- Conflict: fetch 0x0, then 0x100 (same index 0, different tag), then 0x0 -> three misses; miss_count=3; final outInst=0x1000.
- mem_ready asserted only every third cycle during a fill, with addressInst changed to 0x40 mid-fill -> line 0 completes (4 words written), then a new fill starts at mem_addr=0x40.
- invalidate pulsed for 1 cycle mid-fill at cnt=2 -> mem_req low next cycle; state IDLE; a subsequent fetch of 0x0 misses and refills from mem_addr 0x0.
- reset driven low mid-fill -> immediately mem_req=0, counters=0, outStall=1; after release, fetch 0x0 refills from word 0.
